// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared FSM state encoding and grant-index width helper for the CDC FIFO arbiters
package cdc_fifo_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdc_fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index after last (wrapping modulo N)
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx = '0;
    found = |valid;
    // Walk from farthest to nearest so the closest successor of last wins.
    for (int k = N; k >= 1; k--)
      if (valid[(int'(last) + k) % N]) idx = IW'((int'(last) + k) % N);
  end
endmodule

// File: rtl/cdc_fifo_wr_arb.sv
// cdc_fifo_wr_arb: round-robin, burst-bounded arbiter sharing one CDC FIFO write port.
// Define CDC_FIFO_WR_ARB_LAST_EN to add req_last/w_last packet-boundary handling.
module cdc_fifo_wr_arb
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            w_clk,
  input  logic                            w_rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
`ifdef CDC_FIFO_WR_ARB_LAST_EN
  input  logic [NUM_REQ-1:0]              req_last,
  output logic                            w_last,
`endif
  input  logic                            w_full,
  output logic                            w_inc,
  output logic [DATA_WIDTH-1:0]           w_data,
  output logic [id_width(NUM_REQ)-1:0]    grant_id,
  output logic                            busy
);
  localparam int IW = id_width(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t state, state_nx;
  logic [IW-1:0] last_id, pick_id;
  logic [CW-1:0] beat_cnt;
  logic pick_found, cur_valid, end_beat, leave;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid(req_valid),
    .last (last_id),
    .idx  (pick_id),
    .found(pick_found)
  );
  always_comb begin
    busy = state == ST_GRANT;
    cur_valid = req_valid[grant_id];
    w_inc = busy & cur_valid & ~w_full;
    req_ready = busy & ~w_full ? NUM_REQ'(1) << grant_id : '0;
    w_data = busy ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
`ifdef CDC_FIFO_WR_ARB_LAST_EN
    w_last = w_inc & req_last[grant_id];
    end_beat = w_inc & (beat_cnt == CW'(MAX_BURST - 1) | req_last[grant_id]);
`else
    end_beat = w_inc & (beat_cnt == CW'(MAX_BURST - 1));
`endif
    leave = end_beat | ~cur_valid;
    state_nx = busy ? (leave ? ST_IDLE : ST_GRANT) : (pick_found & ~w_full ? ST_GRANT : ST_IDLE);
  end
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      grant_id <= '0;
      last_id  <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else if (!busy) begin
      if (pick_found && !w_full) begin
        grant_id <= pick_id;
        beat_cnt <= '0;
      end
    end else if (leave) begin
      last_id <= grant_id;
    end else if (w_inc) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
endmodule
